// File: rtl/m_definitions_pkg.sv
// Shared definitions for the M-extension coprocessor: mux encodings, their
// widths, operand width and divider step count.
package m_definitions;

    localparam int OPERAND_W = 32;
    localparam int DIV_STEPS = 32;

    localparam int MUX_R_LENGTH       = 2;
    localparam int MUX_D_LENGTH       = 2;
    localparam int MUX_Z_LENGTH       = 2;
    localparam int MUX_MULTA_LENGTH   = 2;
    localparam int MUX_MULTB_LENGTH   = 2;
    localparam int MUX_DIV_REM_LENGTH = 1;
    localparam int MUX_OUT_LENGTH     = 3;

    typedef enum logic [MUX_R_LENGTH-1:0] {
        MUX_R_KEEP     = 2'd0,
        MUX_R_A        = 2'd1,
        MUX_R_A_NEG    = 2'd2,
        MUX_R_SUB_KEEP = 2'd3
    } mux_r_e;

    typedef enum logic [MUX_D_LENGTH-1:0] {
        MUX_D_KEEP  = 2'd0,
        MUX_D_B     = 2'd1,
        MUX_D_B_NEG = 2'd2,
        MUX_D_SHR   = 2'd3
    } mux_d_e;

    typedef enum logic [MUX_Z_LENGTH-1:0] {
        MUX_Z_KEEP    = 2'd0,
        MUX_Z_ZERO    = 2'd1,
        MUX_Z_SHL_ADD = 2'd2
    } mux_z_e;

    typedef enum logic [MUX_MULTA_LENGTH-1:0] {
        MUX_MULTA_ZERO       = 2'd0,
        MUX_MULTA_R_SIGNED   = 2'd1,
        MUX_MULTA_R_UNSIGNED = 2'd2
    } mux_multa_e;

    typedef enum logic [MUX_MULTB_LENGTH-1:0] {
        MUX_MULTB_ZERO       = 2'd0,
        MUX_MULTB_D_SIGNED   = 2'd1,
        MUX_MULTB_D_UNSIGNED = 2'd2
    } mux_multb_e;

    typedef enum logic [MUX_DIV_REM_LENGTH-1:0] {
        MUX_DIV_REM_R = 1'b0,
        MUX_DIV_REM_Z = 1'b1
    } mux_div_rem_e;

    typedef enum logic [MUX_OUT_LENGTH-1:0] {
        MUX_OUT_ZERO        = 3'd0,
        MUX_OUT_MULT_LOWER  = 3'd1,
        MUX_OUT_MULT_UPPER  = 3'd2,
        MUX_OUT_DIV_REM     = 3'd3,
        MUX_OUT_DIV_REM_NEG = 3'd4,
        MUX_OUT_MINUS_1     = 3'd5,
        MUX_OUT_ALL1        = 3'd6
    } mux_out_e;

    function automatic logic [OPERAND_W-1:0] neg32(input logic [OPERAND_W-1:0] v);
        return (~v) + 32'd1;
    endfunction

endpackage

// File: rtl/m_mult33.sv
// Combinational signed 33x33 -> 66-bit multiplier, isolated for later retiming.
module m_mult33 (
    input  logic signed [32:0] a_i,
    input  logic signed [32:0] b_i,
    output logic signed [65:0] p_o
);

    assign p_o = a_i * b_i;

endmodule

// File: rtl/m_datapath.sv
// M-extension datapath: R/D/Z registers, shift-subtract divider step, multiplier
// and result mux. Define M_MUL_EN to instantiate the multiplier (m_mult33).
module m_datapath
    import m_definitions::*;
(
    input  logic                          clk,
    input  logic                          resetn,
    input  logic [OPERAND_W-1:0]          rs1,
    input  logic [OPERAND_W-1:0]          rs2,
    input  logic [OPERAND_W-1:0]          rs1_neg,
    input  logic [OPERAND_W-1:0]          rs2_neg,
    input  logic [MUX_R_LENGTH-1:0]       mux_R,
    input  logic [MUX_D_LENGTH-1:0]       mux_D,
    input  logic [MUX_Z_LENGTH-1:0]       mux_Z,
    input  logic [MUX_MULTA_LENGTH-1:0]   mux_multA,
    input  logic [MUX_MULTB_LENGTH-1:0]   mux_multB,
    input  logic [MUX_DIV_REM_LENGTH-1:0] mux_div_rem,
    input  logic [MUX_OUT_LENGTH-1:0]     mux_out,
    output logic [OPERAND_W-1:0]          pcpi_rd
);

    logic [31:0] r_q, r_d;
    logic [62:0] d_q, d_d;
    logic [31:0] z_q, z_d;
    logic        ge;
    logic [31:0] diff;
    logic [31:0] sel;
    logic signed [65:0] prod;

    // Divisor sits at D[62:31]; once ge holds, D fits in 32 bits so D[31:0] is exact.
    assign ge   = ({31'b0, r_q} >= d_q);
    assign diff = r_q - d_q[31:0];

    always_comb begin
        r_d = r_q;
        d_d = d_q;
        z_d = z_q;
        case (mux_R)
            MUX_R_A:        r_d = rs1;
            MUX_R_A_NEG:    r_d = rs1_neg;
            MUX_R_SUB_KEEP: r_d = ge ? diff : r_q;
            default:        r_d = r_q;
        endcase
        case (mux_D)
            MUX_D_B:     d_d = {rs2, 31'b0};
            MUX_D_B_NEG: d_d = {rs2_neg, 31'b0};
            MUX_D_SHR:   d_d = d_q >> 1;
            default:     d_d = d_q;
        endcase
        case (mux_Z)
            MUX_Z_ZERO:    z_d = '0;
            MUX_Z_SHL_ADD: z_d = {z_q[30:0], ge};
            default:       z_d = z_q;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_q <= '0;
            d_q <= '0;
            z_q <= '0;
        end else begin
            r_q <= r_d;
            d_q <= d_d;
            z_q <= z_d;
        end
    end

`ifdef M_MUL_EN
    logic signed [32:0] op_a;
    logic signed [32:0] op_b;

    // Idle operands are forced to zero to keep the multiplier quiet.
    always_comb begin
        op_a = '0;
        op_b = '0;
        case (mux_multA)
            MUX_MULTA_R_SIGNED:   op_a = {r_q[31], r_q};
            MUX_MULTA_R_UNSIGNED: op_a = {1'b0, r_q};
            default:              op_a = '0;
        endcase
        case (mux_multB)
            MUX_MULTB_D_SIGNED:   op_b = {d_q[62], d_q[62:31]};
            MUX_MULTB_D_UNSIGNED: op_b = {1'b0, d_q[62:31]};
            default:              op_b = '0;
        endcase
    end

    m_mult33 u_mult33 (
        .a_i (op_a),
        .b_i (op_b),
        .p_o (prod)
    );
`else
    logic unused_mult_sel;
    assign unused_mult_sel = ^{mux_multA, mux_multB};
    assign prod = '0;
`endif

    logic unused_prod_hi;
    assign unused_prod_hi = ^prod[65:64];

    assign sel = mux_div_rem[0] ? z_q : r_q;

    always_comb begin
        pcpi_rd = '0;
        case (mux_out)
            MUX_OUT_MULT_LOWER:  pcpi_rd = prod[31:0];
            MUX_OUT_MULT_UPPER:  pcpi_rd = prod[63:32];
            MUX_OUT_DIV_REM:     pcpi_rd = sel;
            MUX_OUT_DIV_REM_NEG: pcpi_rd = neg32(sel);
            MUX_OUT_MINUS_1:     pcpi_rd = 32'hFFFF_FFFF;
            MUX_OUT_ALL1:        pcpi_rd = 32'hFFFF_FFFF;
            default:             pcpi_rd = '0;
        endcase
    end

endmodule

// File: tb/tb_m_datapath.sv
// Directed bench for m_datapath: output-mux and multiplier tables plus divide,
// divide-by-zero, hold and reset-mid-divide sequences.
module tb_m_datapath;
    import m_definitions::*;

`ifdef M_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic        clk;
    logic        resetn;
    logic [31:0] rs1, rs2, rs1_neg, rs2_neg;
    logic [1:0]  mux_R, mux_D, mux_Z, mux_multA, mux_multB;
    logic [0:0]  mux_div_rem;
    logic [2:0]  mux_out;
    logic [31:0] pcpi_rd;

    int checks = 0;
    int errors = 0;

    m_datapath dut (
        .clk         (clk),
        .resetn      (resetn),
        .rs1         (rs1),
        .rs2         (rs2),
        .rs1_neg     (rs1_neg),
        .rs2_neg     (rs2_neg),
        .mux_R       (mux_R),
        .mux_D       (mux_D),
        .mux_Z       (mux_Z),
        .mux_multA   (mux_multA),
        .mux_multB   (mux_multB),
        .mux_div_rem (mux_div_rem),
        .mux_out     (mux_out),
        .pcpi_rd     (pcpi_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  ma;
        logic [1:0]  mb;
        logic [2:0]  out;
        logic [31:0] exp_mul;
    } mvec_t;

    typedef struct {
        string       name;
        logic [2:0]  out;
        logic [0:0]  dr;
        logic [31:0] exp;
    } ovec_t;

    mvec_t mv[11];
    ovec_t ov[8];

    task automatic check(input string name, input logic [31:0] exp);
        #1;
        checks++;
        if (pcpi_rd !== exp) begin
            errors++;
            $display("FAIL %s: pcpi_rd=%h expected %h", name, pcpi_rd, exp);
        end
    endtask

    task automatic read_out(input logic [2:0] out, input logic [0:0] dr, input string name,
                            input logic [31:0] exp);
        mux_out     = out;
        mux_div_rem = dr;
        check(name, exp);
    endtask

    task automatic keep_all();
        mux_R = MUX_R_KEEP;
        mux_D = MUX_D_KEEP;
        mux_Z = MUX_Z_KEEP;
    endtask

    // Load R/D and clear Z in one edge; a_neg selects the A_NEG path for R.
    task automatic load(input logic [31:0] a, input logic [31:0] b, input bit a_neg);
        rs1     = a;
        rs1_neg = -a;
        rs2     = b;
        rs2_neg = -b;
        mux_R   = a_neg ? MUX_R_A_NEG : MUX_R_A;
        mux_D   = MUX_D_B;
        mux_Z   = MUX_Z_ZERO;
        @(posedge clk);
        #1;
        keep_all();
    endtask

    task automatic steps(input int n);
        mux_R = MUX_R_SUB_KEEP;
        mux_D = MUX_D_SHR;
        mux_Z = MUX_Z_SHL_ADD;
        repeat (n) @(posedge clk);
        #1;
        keep_all();
    endtask

    initial begin
        mv[0]  = '{"mulh_ss_upper",   32'h8000_0000, 32'h8000_0000, MUX_MULTA_R_SIGNED,   MUX_MULTB_D_SIGNED,   MUX_OUT_MULT_UPPER, 32'h4000_0000};
        mv[1]  = '{"mulh_ss_lower",   32'h8000_0000, 32'h8000_0000, MUX_MULTA_R_SIGNED,   MUX_MULTB_D_SIGNED,   MUX_OUT_MULT_LOWER, 32'h0000_0000};
        mv[2]  = '{"mulhsu_min",      32'h8000_0000, 32'h8000_0000, MUX_MULTA_R_SIGNED,   MUX_MULTB_D_UNSIGNED, MUX_OUT_MULT_UPPER, 32'hC000_0000};
        mv[3]  = '{"mulhu_min",       32'h8000_0000, 32'h8000_0000, MUX_MULTA_R_UNSIGNED, MUX_MULTB_D_UNSIGNED, MUX_OUT_MULT_UPPER, 32'h4000_0000};
        mv[4]  = '{"mulhsu_m1",       32'hFFFF_FFFF, 32'hFFFF_FFFF, MUX_MULTA_R_SIGNED,   MUX_MULTB_D_UNSIGNED, MUX_OUT_MULT_UPPER, 32'hFFFF_FFFF};
        mv[5]  = '{"mulhu_m1",        32'hFFFF_FFFF, 32'hFFFF_FFFF, MUX_MULTA_R_UNSIGNED, MUX_MULTB_D_UNSIGNED, MUX_OUT_MULT_UPPER, 32'hFFFF_FFFE};
        mv[6]  = '{"mul_m1x2_lower",  32'hFFFF_FFFF, 32'h0000_0002, MUX_MULTA_R_UNSIGNED, MUX_MULTB_D_UNSIGNED, MUX_OUT_MULT_LOWER, 32'hFFFF_FFFE};
        mv[7]  = '{"mulh_m1x2",       32'hFFFF_FFFF, 32'h0000_0002, MUX_MULTA_R_SIGNED,   MUX_MULTB_D_SIGNED,   MUX_OUT_MULT_UPPER, 32'hFFFF_FFFF};
        mv[8]  = '{"mulhu_m1x2",      32'hFFFF_FFFF, 32'h0000_0002, MUX_MULTA_R_UNSIGNED, MUX_MULTB_D_UNSIGNED, MUX_OUT_MULT_UPPER, 32'h0000_0001};
        mv[9]  = '{"mul_opa_zero",    32'hFFFF_FFFF, 32'h0000_0002, MUX_MULTA_ZERO,       MUX_MULTB_D_UNSIGNED, MUX_OUT_MULT_LOWER, 32'h0000_0000};
        mv[10] = '{"mul_opb_zero",    32'hFFFF_FFFF, 32'h0000_0002, MUX_MULTA_R_UNSIGNED, MUX_MULTB_ZERO,       MUX_OUT_MULT_LOWER, 32'h0000_0000};

        // State after DIVU 100/7: R=2, Z=14.
        ov[0] = '{"divu_quot",     MUX_OUT_DIV_REM,     MUX_DIV_REM_Z, 32'd14};
        ov[1] = '{"divu_rem",      MUX_OUT_DIV_REM,     MUX_DIV_REM_R, 32'd2};
        ov[2] = '{"rem_neg",       MUX_OUT_DIV_REM_NEG, MUX_DIV_REM_R, 32'hFFFF_FFFE};
        ov[3] = '{"quot_neg",      MUX_OUT_DIV_REM_NEG, MUX_DIV_REM_Z, 32'hFFFF_FFF2};
        ov[4] = '{"minus_1",       MUX_OUT_MINUS_1,     MUX_DIV_REM_Z, 32'hFFFF_FFFF};
        ov[5] = '{"all1",          MUX_OUT_ALL1,        MUX_DIV_REM_R, 32'hFFFF_FFFF};
        ov[6] = '{"out_zero",      MUX_OUT_ZERO,        MUX_DIV_REM_Z, 32'h0000_0000};
        ov[7] = '{"out_sel7",      3'd7,                MUX_DIV_REM_R, 32'h0000_0000};

        rs1 = '0; rs2 = '0; rs1_neg = '0; rs2_neg = '0;
        keep_all();
        mux_multA = MUX_MULTA_ZERO;
        mux_multB = MUX_MULTB_ZERO;
        mux_div_rem = MUX_DIV_REM_R;
        mux_out = MUX_OUT_ZERO;
        resetn = 1'b0;

        check("reset_out_zero", 32'h0);
        read_out(MUX_OUT_DIV_REM, MUX_DIV_REM_R, "reset_R", 32'h0);
        read_out(MUX_OUT_DIV_REM, MUX_DIV_REM_Z, "reset_Z", 32'h0);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // DIVU 100 / 7
        load(32'd100, 32'd7, 1'b0);
        steps(DIV_STEPS);
        for (int i = 0; i < 8; i++) read_out(ov[i].out, ov[i].dr, ov[i].name, ov[i].exp);

        // Z KEEP and the reserved encoding 3 both hold; ZERO clears Z alone.
        mux_Z = 2'd3;
        repeat (3) @(posedge clk);
        #1;
        mux_Z = MUX_Z_KEEP;
        read_out(MUX_OUT_DIV_REM, MUX_DIV_REM_Z, "z_hold_sel3", 32'd14);
        mux_Z = MUX_Z_ZERO;
        @(posedge clk);
        #1;
        mux_Z = MUX_Z_KEEP;
        read_out(MUX_OUT_DIV_REM, MUX_DIV_REM_Z, "z_zero", 32'd0);
        read_out(MUX_OUT_DIV_REM, MUX_DIV_REM_R, "r_kept", 32'd2);

        // Signed DIV -100 / 7 via A_NEG, quotient negated on output
        load(-32'sd100, 32'd7, 1'b1);
        steps(DIV_STEPS);
        read_out(MUX_OUT_DIV_REM_NEG, MUX_DIV_REM_Z, "sdiv_quot", 32'hFFFF_FFF2);
        read_out(MUX_OUT_DIV_REM_NEG, MUX_DIV_REM_R, "sdiv_rem", 32'hFFFF_FFFE);

        // Largest dividend over divisor 1
        load(32'hFFFF_FFFF, 32'd1, 1'b0);
        steps(DIV_STEPS);
        read_out(MUX_OUT_DIV_REM, MUX_DIV_REM_Z, "div_max_quot", 32'hFFFF_FFFF);
        read_out(MUX_OUT_DIV_REM, MUX_DIV_REM_R, "div_max_rem", 32'h0);

        // Divide by zero: ge on every step, R untouched
        load(32'd5, 32'd0, 1'b0);
        steps(DIV_STEPS);
        read_out(MUX_OUT_DIV_REM, MUX_DIV_REM_Z, "div0_quot", 32'hFFFF_FFFF);
        read_out(MUX_OUT_DIV_REM, MUX_DIV_REM_R, "div0_rem", 32'd5);

        // Multiplier table; results read 0 when the multiplier is compiled out.
        for (int i = 0; i < 11; i++) begin
            load(mv[i].a, mv[i].b, 1'b0);
            mux_multA = mv[i].ma;
            mux_multB = mv[i].mb;
            read_out(mv[i].out, MUX_DIV_REM_R, mv[i].name, MUL_EN ? mv[i].exp_mul : 32'h0);
            mux_multA = MUX_MULTA_ZERO;
            mux_multB = MUX_MULTB_ZERO;
        end
        mux_out = MUX_OUT_ZERO;

        // Reset asserted mid-divide, away from any clock edge
        load(32'd100, 32'd7, 1'b0);
        steps(10);
        read_out(MUX_OUT_DIV_REM, MUX_DIV_REM_R, "pre_reset_R", 32'd100);
        @(negedge clk);
        #2;
        resetn = 1'b0;
        read_out(MUX_OUT_DIV_REM, MUX_DIV_REM_R, "midreset_R", 32'h0);
        read_out(MUX_OUT_DIV_REM, MUX_DIV_REM_Z, "midreset_Z", 32'h0);
        read_out(MUX_OUT_ZERO, MUX_DIV_REM_R, "midreset_out", 32'h0);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // D must be cleared too: reload R only and divide by the held D (=0).
        rs1 = 32'd100;
        mux_R = MUX_R_A;
        mux_Z = MUX_Z_ZERO;
        @(posedge clk);
        #1;
        keep_all();
        mux_multA = MUX_MULTA_R_UNSIGNED;
        mux_multB = MUX_MULTB_D_UNSIGNED;
        read_out(MUX_OUT_MULT_LOWER, MUX_DIV_REM_R, "post_reset_D_mul", 32'h0);
        mux_multA = MUX_MULTA_ZERO;
        mux_multB = MUX_MULTB_ZERO;
        steps(DIV_STEPS);
        read_out(MUX_OUT_DIV_REM, MUX_DIV_REM_Z, "post_reset_D_quot", 32'hFFFF_FFFF);
        read_out(MUX_OUT_DIV_REM, MUX_DIV_REM_R, "post_reset_D_rem", 32'd100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/m_datapath.md
# m_datapath

Arithmetic datapath for the PCPI M-extension coprocessor, downstream of `m_controller`. It holds the remainder (R), divisor (D) and quotient (Z) registers and the shift-subtract divider step. It also contains the 33x33 multiplier and the result mux that drives `pcpi_rd` back to the core. It makes no decisions of its own: every register update and output selection follows the controller's mux selects.

## Interface
- No parameters; all widths fixed by RV32M.
- clk  in  1  clock.
- resetn  in  1  reset, asynchronous, active-low.
- rs1, rs2  in  32  operands from PCPI.
- rs1_neg, rs2_neg  in  32  two's-complement negations from the controller.
- mux_R  in  2  KEEP=0, A=1, A_NEG=2, SUB_KEEP=3.
- mux_D  in  2  KEEP=0, B=1, B_NEG=2, SHR=3.
- mux_Z  in  2  KEEP=0, ZERO=1, SHL_ADD=2 (3 behaves as KEEP).
- mux_multA  in  2  ZERO=0, R_SIGNED=1, R_UNSIGNED=2.
- mux_multB  in  2  ZERO=0, D_SIGNED=1, D_UNSIGNED=2.
- mux_div_rem  in  1  R=0, Z=1.
- mux_out  in  3  ZERO=0, MULT_LOWER=1, MULT_UPPER=2, DIV_REM=3, DIV_REM_NEG=4, MINUS_1=5, ALL1=6; 7 behaves as ZERO.
- pcpi_rd  out  32  result to the core.

## Operation
- Registers:
  - R: 32 bits.
  - D: 63 bits. The divisor is held at D[62:31], so the load value is {operand, 31'b0}.
  - Z: 32 bits.
- Divider step, combinational:
  - ge = ({31'b0, R} >= D).
  - diff = R - D[31:0], valid only when ge.
- R update:
  - A: R ← rs1.
  - A_NEG: R ← rs1_neg.
  - SUB_KEEP: R ← ge ? diff : R.
  - KEEP: hold.
- D update:
  - B: D ← {rs2, 31'b0}.
  - B_NEG: D ← {rs2_neg, 31'b0}.
  - SHR: D ← D >> 1.
  - KEEP: hold.
- Z update:
  - ZERO: Z ← 0.
  - SHL_ADD: Z ← {Z[30:0], ge}.
  - KEEP: hold.
- All three updates apply in the same clock edge. ge is computed from pre-edge values.
- After 32 consecutive SUB_KEEP/SHR/SHL_ADD cycles, Z holds the unsigned quotient and R the unsigned remainder of the loaded magnitudes.
- Multiplier operands:
  - opA is 33 bits. R_SIGNED: {R[31], R}. R_UNSIGNED: {1'b0, R}. ZERO: 0.
  - opB is 33 bits from D[62:31]. D_SIGNED sign-extends, D_UNSIGNED zero-extends, ZERO gives 0.
  - ZERO forces the operand to 0 so the multiplier does not toggle while idle.
- prod = signed 66-bit opA*opB. MULT_LOWER = prod[31:0]; MULT_UPPER = prod[63:32].
- sel = mux_div_rem ? Z : R.
- pcpi_rd selection:
  - DIV_REM: sel.
  - DIV_REM_NEG: -sel, mod 2^32.
  - MINUS_1 and ALL1: 32'hFFFF_FFFF.
  - ZERO: 0.

## Timing
- Reset: R, D, Z = 0 immediately on resetn low, independent of clk. pcpi_rd = 0 for as long as mux_out = ZERO.
- Operand load: on the edge at which the controller leaves IDLE. R/D are valid in the next cycle.
- Multiply: pcpi_rd is combinational and valid in the controller's DONE cycle, one cycle after load. Total latency 2 cycles from pcpi_valid.
- Divide: 1 load cycle, then 32 DIVID cycles, then SELECT, then DONE. pcpi_rd is valid in DONE, 35 cycles after pcpi_valid.
- pcpi_rd is purely combinational from the registers and selects; it has no output register.
- Reset asserted mid-divide: all registers clear; no partial state survives.
- A load select during a step has priority by construction, because the encodings are exclusive.
- D = 0 (divide by zero) runs a full division without error. ge = 1 on every step, but the controller never routes Z to pcpi_rd in this case.

## Configuration
- `M_MUL_EN`, defined: the multiplier is instantiated as above.
- `M_MUL_EN`, undefined:
  - No multiplier logic is instantiated.
  - prod = 0, so MULT_LOWER and MULT_UPPER return 0.
  - mux_multA and mux_multB are ignored.
  - Divider behaviour is unchanged.

## Structure
- Shared package/header `m_definitions`:
  - all mux encodings and their `_LENGTH` widths;
  - the operand width (32) and divider step count (32).
- Sub-module `m_mult33`: purely combinational, signed 33x33 → 66-bit multiplier.
  - Instantiated only under `M_MUL_EN`.
  - Kept separate so the team can later retime or replace it.
- R/D/Z register updates and the output mux stay in `m_datapath`.

## Test plan
- DIVU: load R=100 (A), D=7 (B), Z ZERO; 32 step cycles → Z=14, R=2. div_rem=Z with DIV_REM → 14; div_rem=R → 2.
- Signed DIV: rs1=-100 loaded via A_NEG, rs2=7 via B; 32 steps; div_rem=Z with DIV_REM_NEG → pcpi_rd=0xFFFF_FFF2 (-14).
- MULH: R=0x8000_0000, D=0x8000_0000, both signed selects, MULT_UPPER → 0x4000_0000.
- MULHSU: R=0xFFFF_FFFF signed, D=0xFFFF_FFFF unsigned, MULT_UPPER → 0xFFFF_FFFF. MUL of 0xFFFF_FFFF×2 with MULT_LOWER → 0xFFFF_FFFE.
- Reset mid-divide: pulse resetn low after step 10 → R=D=Z=0 immediately; pcpi_rd=0 with mux_out=ZERO.
- `M_MUL_EN` undefined: the MULH case above → pcpi_rd=0; the DIVU case is unchanged.
